enc4to2_arb: RTL
================

# enc4to2_arb

Registered 4-to-2 request encoder with round-robin arbitration. It is the encode-direction counterpart of the 2-to-4 decoders used for register and unit selection. It collects up to four single-cycle request strobes, holds them as pending, and presents one 2-bit index at a time to a consumer through a valid/ack handshake. It sits between request sources (e.g. functional units raising completion or exception lines) and the control logic that needs a binary index.

## Interface
- No parameters; the width is fixed at 4 requests and a 2-bit code.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; dominates every other input.
- `en`  in  1  grant enable; when 0, no new grant is issued (requests are still latched).
- `req`  in  4  request strobes; any bit high for a cycle sets that bit's pending flag.
- `ack`  in  1  consumer accepts the current code; ignored unless `valid`=1.
- `code`  out  2  index of the granted request; stable while `valid`=1.
- `valid`  out  1  `code` holds a granted request awaiting ack.
- `ovf`  out  1  sticky; set when a request hits an already-pending bit that is not being cleared that cycle.

## Operation
- State:
  - `pending[3:0]`
  - `ptr[1:0]`: round-robin start index
  - FSM {IDLE, BUSY}
  - `code` register
  - `ovf` register
- All outputs come directly from registers; there is no combinational path from inputs to outputs.
- Selection function `sel(p, ptr)`: the first set bit of `p` scanning `ptr`, `ptr+1`, ... modulo 4.
- Pending update, every cycle: `pending <= (pending & ~clr) | req`.
  - `clr` = one-hot(`code`) when state is BUSY and `ack`=1; otherwise 0.
  - Set wins over clear on the same bit in the same cycle.
- IDLE:
  - `valid`=0.
  - If `en`=1 and `pending`≠0 (the registered value only, not this cycle's `req`): `code <= sel(pending, ptr)`, go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - `valid`=1; `code` is held.
  - `en` is ignored, so an issued grant always completes.
  - On `ack`=1: clear `pending[code]` (subject to set-wins), set `ptr <= code+1` (wraps 3→0), go to IDLE.
- `ovf` is set when, for any i, `req[i]`=1 and `pending[i]`=1 and bit i is not in `clr`. It is cleared only by reset. The duplicate request is merged, not queued.
- Reset values: `pending`=0, `ptr`=0, state=IDLE, `code`=2'b00, `valid`=0, `ovf`=0.
- Reset mid-BUSY drops the grant and all pending requests; `valid`=0 the following cycle.
- `req` asserted during reset is discarded.

## Timing
- Request to valid:
  - `req` high in cycle N → pending set at the end of N.
  - Grant chosen in cycle N+1 → `valid`=1 in cycle N+2 (latency 2), given `en`=1 and state IDLE.
- Ack to release: `ack` in cycle K with `valid`=1 → `valid`=0 in K+1, which is always one IDLE cycle.
  - Next grant at the earliest in K+2.
  - Maximum throughput is one grant per 2 cycles.
- `ptr` and `pending` changes from an ack take effect for the selection made in cycle K+1.
- `en` low in cycle N blocks a grant decision in N only; a BUSY already in progress is unaffected.
- `ovf` rises the cycle after the offending `req`.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `req`=4'b1111.
  - Afterwards `valid`=0, `code`=0, `ovf`=0.
  - No grant ever appears without a new `req`.
- **Single request:** `req`=4'b0100 for 1 cycle, `en`=1.
  - `valid`=1, `code`=2 two cycles later; held for 5 cycles with `ack`=0.
  - `ack` 1 cycle → `valid`=0 next cycle and stays 0.
- **All requests:** `req`=4'b1111 for 1 cycle from reset (`ptr`=0), with `ack` pulsed on each valid.
  - Codes are 0, 1, 2, 3 in order, each `valid` separated by exactly one low cycle.
  - `ptr` returns to 0.
- **Round-robin wrap:** serve `code`=2 (`ptr` becomes 3), then `req`=4'b0101.
  - Grant order is 0, then 2.
  - Then `req`=4'b1001 → 3, then 0.
- **Set-wins and overflow:**
  - `req[1]`=1 in the same cycle as `ack` of `code`=1, with nothing else pending → `valid`=1 with `code`=1 again two cycles later, and `ovf` stays 0.
  - Later, `req[0]` repeated while `pending[0]`=1 and not acked → `ovf`=1 and stays 1 until reset.
- **Enable and mid-operation reset:**
  - `en`=0 with `req`=4'b0010 → `valid` stays 0; raise `en` → `valid`=1, `code`=1 after 1 cycle.
  - Assert `reset` while BUSY → `valid`=0 the next cycle and `pending` is empty.

Source files
------------

// File: rtl/enc4to2_arb_if.sv
// Request/grant bundle for the 4-to-2 round-robin encoder.
// The master side raises requests and acknowledges grants.
// The slave side (the encoder) returns the granted index.
interface enc4to2_arb_if;
  logic [3:0] req;
  logic       en;
  logic       ack;
  logic [1:0] code;
  logic       valid;
  logic       ovf;

  modport master (
    output req,
    output en,
    output ack,
    input  code,
    input  valid,
    input  ovf
  );

  modport slave (
    input  req,
    input  en,
    input  ack,
    output code,
    output valid,
    output ovf
  );
endinterface

// File: rtl/enc4to2_arb.sv
// Registered 4-to-2 request encoder with round-robin arbitration.
// Single-cycle request strobes are collected into pending flags. One
// pending index at a time is offered to the consumer through valid/ack.
// All outputs come straight from flops.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | no grant outstanding; may pick from registered pending
//   BUSY  | code holds a grant awaiting ack; en is ignored here
module enc4to2_arb (
  input  logic               clk,
  input  logic               reset,
  enc4to2_arb_if.slave       bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] code_q, code_d;
  logic       ovf_q, ovf_d;
  logic [3:0] clr;

  // First set bit of p, scanning from start upward modulo 4.
  function automatic logic [1:0] sel_idx(input logic [3:0] p,
                                         input logic [1:0] start);
    logic [1:0] idx;
    logic       found;
    sel_idx = start;
    found   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && p[idx]) begin
        sel_idx = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // Next-state, pending merge, grant selection and overflow detection.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    code_d    = code_q;
    clr       = 4'b0000;

    // Only an ack of a live grant retires its pending bit.
    if (state_q == BUSY && bus.ack) begin
      clr = 4'b0001 << code_q;
    end

    // A request landing on the bit being cleared wins (re-arms it).
    pending_d = (pending_q & ~clr) | bus.req;

    // A duplicate on a bit that stays pending is merged and flagged.
    ovf_d     = ovf_q | (|(bus.req & pending_q & ~clr));

    case (state_q)
      IDLE: begin
        // Decide from the registered pending only, so req never reaches
        // code/valid in the same cycle.
        if (bus.en && (pending_q != 4'b0000)) begin
          code_d  = sel_idx(pending_q, ptr_q);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.ack) begin
          ptr_d   = code_q + 2'd1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; synchronous reset drops grants and pending requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= 4'b0000;
      ptr_q     <= 2'b00;
      code_q    <= 2'b00;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      code_q    <= code_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.code  = code_q;
  assign bus.valid = (state_q == BUSY);
  assign bus.ovf   = ovf_q;

endmodule
